// File: rtl/io_fifo_pkg.sv
// io_fifo_pkg
// Shared definitions for the io_fifo_port peripheral: register offsets,
// STATUS/CTRL bit positions, the bus-cycle FSM state type and a helper
// that packs the STATUS byte.
package io_fifo_pkg;

   // Register offsets within the 4-byte window
   localparam logic [1:0] OFF_DATA   = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;
   localparam logic [1:0] OFF_COUNT  = 2'd2;
   localparam logic [1:0] OFF_CTRL   = 2'd3;

   // STATUS bit positions
   localparam int STS_TX_FULL  = 32'sd0;
   localparam int STS_TX_EMPTY = 32'sd1;
   localparam int STS_RX_FULL  = 32'sd2;
   localparam int STS_RX_EMPTY = 32'sd3;
   localparam int STS_TX_OVF   = 32'sd4;
   localparam int STS_RX_UDF   = 32'sd5;

   // CTRL bit positions
   localparam int CTRL_RX_IRQ_EN = 32'sd0;
   localparam int CTRL_TX_IRQ_EN = 32'sd1;
   localparam int CTRL_FLUSH     = 32'sd7;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RD_ACT = 2'd1,
      ST_WR_ACT = 2'd2
   } bus_state_t;

   function automatic logic [7:0] pack_status(input logic tx_full, input logic tx_empty,
                                              input logic rx_full, input logic rx_empty,
                                              input logic tx_ovf,  input logic rx_udf);
      logic [7:0] s;
      s               = 8'h00;
      s[STS_TX_FULL]  = tx_full;
      s[STS_TX_EMPTY] = tx_empty;
      s[STS_RX_FULL]  = rx_full;
      s[STS_RX_EMPTY] = rx_empty;
      s[STS_TX_OVF]   = tx_ovf;
      s[STS_RX_UDF]   = rx_udf;
      return s;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock FIFO with occupancy count. A push while full is accepted only
// when a pop happens in the same cycle; flush empties the FIFO and overrides
// any coincident push/pop.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   push, pop, flush   requests (pop ignored when empty)
//   din                write data
//   count              occupancy, AW+1 bits
//   full, empty        derived from count
//   head               entry at the read pointer
module sync_fifo #(
   parameter  int DEPTH = 8,
   parameter  int W     = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic [W-1:0]  din,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty,
   output logic [W-1:0]  head
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW:0]   count_r;
   logic          do_push_s;
   logic          do_pop_s;

   assign count = count_r;
   assign full  = (count_r == FULL_CNT);
   assign empty = (count_r == '0);
   assign head  = mem_r[rd_ptr_r];

   // Qualify requests; a full FIFO still takes a push when it also pops
   always_comb begin
      do_pop_s  = pop & ~empty;
      do_push_s = push & (~full | do_pop_s);
   end

   // Pointer and occupancy tracking
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else if (flush) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
         if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1'b1);
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + (AW+1)'(1'b1);
            2'b01:   count_r <= count_r - (AW+1)'(1'b1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Storage array; contents after reset are irrelevant
   always_ff @(posedge clk) begin
      if (do_push_s) mem_r[wr_ptr_r] <= din;
   end

endmodule

// File: rtl/io_fifo_port.sv
// io_fifo_port
// I/O-mapped byte FIFO peripheral for the 8088 bus. Registers at BASE+0..3:
// DATA (R pops RX, W pushes TX), STATUS, COUNT, CTRL (irq enables, flush).
// Bus accesses run through a three-state FSM that applies exactly one side
// effect per bus cycle, on the first clock that sees the strobe released.
// Optional macro IO_FIFO_IRQ_EN: enables the INTR output and the writable
// CTRL[1:0] interrupt enables; without it INTR is 0 and CTRL[1:0] read 0.
// Ports:
//   CLK, RESET_N           bus clock, asynchronous active-low reset
//   CS, IOM, ADDR          decode inputs (ADDR[15:0] compared)
//   RD_N, WR_N             bus strobes, active low
//   DATA_IN/DATA_OUT/DATA_OE  transceiver data path
//   TX_DATA/TX_VALID/TX_READY device-side TX stream
//   RX_DATA/RX_VALID/RX_READY device-side RX stream
//   INTR                   interrupt request
module io_fifo_port
   import io_fifo_pkg::*;
#(
   parameter  logic [15:0] BASE  = 16'h1C10,
   parameter  int          DEPTH = 8,
   localparam int          AW    = $clog2(DEPTH)
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        CS,
   input  logic        IOM,
   input  logic [19:0] ADDR,
   input  logic        RD_N,
   input  logic        WR_N,
   input  logic [7:0]  DATA_IN,
   output logic [7:0]  DATA_OUT,
   output logic        DATA_OE,
   output logic [7:0]  TX_DATA,
   output logic        TX_VALID,
   input  logic        TX_READY,
   input  logic [7:0]  RX_DATA,
   input  logic        RX_VALID,
   output logic        RX_READY,
   output logic        INTR
);

   bus_state_t  state_r;
   logic [1:0]  off_r;
   logic [7:0]  wdata_r;
   logic        rd_empty_r;   // RX was empty when the read began
   logic        tx_ovf_r;
   logic        rx_udf_r;
   logic        rx_irq_en;
   logic        tx_irq_en;

   logic        hit_s;
   logic        tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;
   logic        flush_s, ctrl_wr_s, sts_clr_s, udf_set_s;
   logic [7:0]  rdata_s;

   logic [AW:0] tx_count, rx_count;
   logic        tx_full, tx_empty, rx_full, rx_empty;
   logic [7:0]  rx_head;

   logic        unused_addr_s;
   assign unused_addr_s = ^ADDR[19:16];

   assign hit_s     = CS & IOM & (ADDR[15:2] == BASE[15:2]);
   assign tx_pop_s  = ~tx_empty & TX_READY;
   assign rx_push_s = RX_VALID & ~rx_full;
   assign TX_VALID  = ~tx_empty;
   assign RX_READY  = ~rx_full;

   sync_fifo #(.DEPTH(DEPTH), .W(8)) u_tx_fifo (
      .clk(CLK), .rst_n(RESET_N), .push(tx_push_s), .pop(tx_pop_s), .flush(flush_s),
      .din(wdata_r), .count(tx_count), .full(tx_full), .empty(tx_empty), .head(TX_DATA)
   );

   sync_fifo #(.DEPTH(DEPTH), .W(8)) u_rx_fifo (
      .clk(CLK), .rst_n(RESET_N), .push(rx_push_s), .pop(rx_pop_s), .flush(flush_s),
      .din(RX_DATA), .count(rx_count), .full(rx_full), .empty(rx_empty), .head(rx_head)
   );

   // Side-effect pulses, asserted only on the clock that closes a bus cycle
   always_comb begin
      tx_push_s = 1'b0;
      rx_pop_s  = 1'b0;
      flush_s   = 1'b0;
      ctrl_wr_s = 1'b0;
      sts_clr_s = 1'b0;
      udf_set_s = 1'b0;
      if (state_r == ST_WR_ACT && WR_N) begin
         case (off_r)
            OFF_DATA: tx_push_s = 1'b1;
            OFF_CTRL: begin
               ctrl_wr_s = 1'b1;
               flush_s   = wdata_r[CTRL_FLUSH];
            end
            default: ;
         endcase
      end else if (state_r == ST_RD_ACT && RD_N) begin
         case (off_r)
            OFF_DATA: begin
               rx_pop_s  = ~rd_empty_r;
               udf_set_s = rd_empty_r;
            end
            OFF_STATUS: sts_clr_s = 1'b1;
            default: ;
         endcase
      end else begin
         tx_push_s = 1'b0;
      end
   end

   // Read-data mux, evaluated at the entry of a read cycle
   always_comb begin
      rdata_s = 8'h00;
      case (ADDR[1:0])
         OFF_DATA:   rdata_s = rx_empty ? 8'h00 : rx_head;
         OFF_STATUS: rdata_s = pack_status(tx_full, tx_empty, rx_full, rx_empty, tx_ovf_r, rx_udf_r);
         OFF_COUNT:  rdata_s = {4'(rx_count), 4'(tx_count)};
         OFF_CTRL:   rdata_s = {6'b000000, tx_irq_en, rx_irq_en};
         default:    rdata_s = 8'h00;
      endcase
   end

   // Bus-cycle FSM with registered read data and drive enable
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_r    <= ST_IDLE;
         DATA_OE    <= 1'b0;
         DATA_OUT   <= 8'h00;
         off_r      <= 2'd0;
         wdata_r    <= 8'h00;
         rd_empty_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               // both strobes low is a write, so WR_N is tested first
               if (hit_s && !WR_N) begin
                  state_r <= ST_WR_ACT;
                  off_r   <= ADDR[1:0];
                  wdata_r <= DATA_IN;
               end else if (hit_s && !RD_N) begin
                  state_r    <= ST_RD_ACT;
                  off_r      <= ADDR[1:0];
                  DATA_OUT   <= rdata_s;
                  DATA_OE    <= 1'b1;
                  rd_empty_r <= rx_empty;
               end
            end
            ST_RD_ACT: begin
               if (RD_N) begin
                  DATA_OE <= 1'b0;
                  state_r <= ST_IDLE;
               end
            end
            ST_WR_ACT: begin
               if (!WR_N) wdata_r <= DATA_IN;
               else       state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
               DATA_OE <= 1'b0;
            end
         endcase
      end
   end

   // Sticky error flags; a new error in the clearing cycle wins
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         tx_ovf_r <= 1'b0;
         rx_udf_r <= 1'b0;
      end else begin
         if (tx_push_s && tx_full && !tx_pop_s) tx_ovf_r <= 1'b1;
         else if (sts_clr_s)                    tx_ovf_r <= 1'b0;
         if (udf_set_s)                         rx_udf_r <= 1'b1;
         else if (sts_clr_s)                    rx_udf_r <= 1'b0;
      end
   end

`ifdef IO_FIFO_IRQ_EN
   logic intr_r;
   assign INTR = intr_r;

   // Interrupt enables and registered interrupt request
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         rx_irq_en <= 1'b0;
         tx_irq_en <= 1'b0;
         intr_r    <= 1'b0;
      end else begin
         if (ctrl_wr_s) begin
            rx_irq_en <= wdata_r[CTRL_RX_IRQ_EN];
            tx_irq_en <= wdata_r[CTRL_TX_IRQ_EN];
         end
         intr_r <= (rx_irq_en & ~rx_empty) | (tx_irq_en & tx_empty);
      end
   end
`else
   logic unused_ctrl_s;
   assign unused_ctrl_s = ctrl_wr_s;
   assign rx_irq_en     = 1'b0;
   assign tx_irq_en     = 1'b0;
   assign INTR          = 1'b0;
`endif

endmodule

// File: tb/tb_io_fifo_port.sv
// tb_io_fifo_port
// Directed bench for io_fifo_port: register reads after reset, TX push and
// drain, TX overflow, RX pop/underflow, simultaneous push/pop at full, RX
// full, flush, reset in the middle of bus cycles, and the interrupt path.
module tb_io_fifo_port;

   logic        CLK = 1'b0;
   logic        RESET_N, CS, IOM, RD_N, WR_N, TX_READY, RX_VALID;
   logic [19:0] ADDR;
   logic [7:0]  DATA_IN, RX_DATA;
   logic [7:0]  DATA_OUT, TX_DATA;
   logic        DATA_OE, TX_VALID, RX_READY, INTR;

   int checks = 0;
   int errors = 0;

   localparam logic [19:0] A_DATA = 20'h01C10;
   localparam logic [19:0] A_STS  = 20'h01C11;
   localparam logic [19:0] A_CNT  = 20'h01C12;
   localparam logic [19:0] A_CTRL = 20'h01C13;
   localparam logic [19:0] A_MISS = 20'h01C14;

`ifdef IO_FIFO_IRQ_EN
   localparam logic [7:0] CTRL_EXP = 8'h03;
   localparam logic       IRQ_ON   = 1'b1;
`else
   localparam logic [7:0] CTRL_EXP = 8'h00;
   localparam logic       IRQ_ON   = 1'b0;
`endif

   io_fifo_port dut (
      .CLK(CLK), .RESET_N(RESET_N), .CS(CS), .IOM(IOM), .ADDR(ADDR),
      .RD_N(RD_N), .WR_N(WR_N), .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT),
      .DATA_OE(DATA_OE), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID),
      .TX_READY(TX_READY), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
      .RX_READY(RX_READY), .INTR(INTR)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge, returns at a negedge just after the commit edge
   task automatic bus_write(input logic [19:0] a, input logic [7:0] d, input logic dev_pop);
      CS = 1'b1; IOM = 1'b1; ADDR = a; DATA_IN = d; WR_N = 1'b0;
      @(negedge CLK);
      WR_N = 1'b1;
      if (dev_pop) TX_READY = 1'b1;
      @(negedge CLK);
      CS = 1'b0;
      if (dev_pop) TX_READY = 1'b0;
   endtask

   task automatic bus_read(input logic [19:0] a, output logic [7:0] d);
      CS = 1'b1; IOM = 1'b1; ADDR = a; RD_N = 1'b0;
      @(negedge CLK);
      check("oe_during_read", DATA_OE, 1'b1);
      d = DATA_OUT;
      RD_N = 1'b1;
      @(negedge CLK);
      check("oe_after_read", DATA_OE, 1'b0);
      CS = 1'b0;
   endtask

   task automatic dev_push(input logic [7:0] d);
      RX_VALID = 1'b1; RX_DATA = d;
      @(negedge CLK);
      RX_VALID = 1'b0;
   endtask

   logic [7:0] rd;

   initial begin
      RESET_N = 1'b0; CS = 1'b0; IOM = 1'b0; RD_N = 1'b1; WR_N = 1'b1;
      ADDR = 20'h00000; DATA_IN = 8'h00; RX_DATA = 8'h00; RX_VALID = 1'b0; TX_READY = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      check("rst_tx_valid", TX_VALID, 1'b0);
      check("rst_rx_ready", RX_READY, 1'b1);
      check("rst_oe", DATA_OE, 1'b0);
      check("rst_dout", DATA_OUT, 8'h00);
      check("rst_intr", INTR, 1'b0);
      RESET_N = 1'b1;
      @(negedge CLK);

      bus_read(A_STS, rd); check("status_reset", rd, 8'h0A);
      bus_read(A_CNT, rd); check("count_reset", rd, 8'h00);
      bus_write(A_MISS, 8'hFF, 1'b0);
      bus_read(A_CNT, rd); check("count_after_miss", rd, 8'h00);

      // Two pushes, then drain
      bus_write(A_DATA, 8'hA5, 1'b0);
      check("tx_valid_after_push", TX_VALID, 1'b1);
      bus_write(A_DATA, 8'h3C, 1'b0);
      bus_read(A_CNT, rd); check("count_two", rd, 8'h02);
      check("tx_head_a5", TX_DATA, 8'hA5);
      TX_READY = 1'b1;
      @(negedge CLK);
      check("tx_head_3c", TX_DATA, 8'h3C);
      check("tx_valid_mid", TX_VALID, 1'b1);
      @(negedge CLK);
      check("tx_valid_drained", TX_VALID, 1'b0);
      TX_READY = 1'b0;

      // Overflow: nine pushes into an 8-deep FIFO
      for (int i = 0; i < 9; i++) bus_write(A_DATA, 8'h10 + 8'(i), 1'b0);
      bus_read(A_STS, rd); check("status_ovf", rd, 8'h19);
      bus_read(A_STS, rd); check("status_ovf_cleared", rd, 8'h09);
      bus_read(A_CNT, rd); check("count_full", rd, 8'h08);

      // Push while full with a coincident device pop
      bus_write(A_DATA, 8'hEE, 1'b1);
      bus_read(A_CNT, rd); check("count_full_simul", rd, 8'h08);
      bus_read(A_STS, rd); check("status_no_ovf", rd, 8'h09);
      TX_READY = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("tx_order", TX_DATA, (i < 7) ? (8'h11 + 8'(i)) : 8'hEE);
         @(negedge CLK);
      end
      check("tx_empty_after_order", TX_VALID, 1'b0);
      TX_READY = 1'b0;

      // RX path and underflow
      dev_push(8'h11);
      dev_push(8'h22);
      bus_read(A_CNT, rd);  check("count_rx_two", rd, 8'h20);
      bus_read(A_DATA, rd); check("rx_pop_11", rd, 8'h11);
      bus_read(A_DATA, rd); check("rx_pop_22", rd, 8'h22);
      bus_read(A_DATA, rd); check("rx_pop_empty", rd, 8'h00);
      bus_read(A_STS, rd);  check("status_udf", rd, 8'h2A);
      bus_read(A_STS, rd);  check("status_udf_cleared", rd, 8'h0A);

      // RX full: ninth byte ignored
      for (int i = 0; i < 9; i++) dev_push(8'h30 + 8'(i));
      check("rx_ready_full", RX_READY, 1'b0);
      bus_read(A_CNT, rd);  check("count_rx_full", rd, 8'h80);
      bus_read(A_STS, rd);  check("status_rx_full", rd, 8'h06);
      bus_read(A_DATA, rd); check("rx_pop_30", rd, 8'h30);
      check("rx_ready_after_pop", RX_READY, 1'b1);

      // Flush and CTRL readback
      bus_write(A_CTRL, 8'h83, 1'b0);
      bus_read(A_CNT, rd);  check("count_flushed", rd, 8'h00);
      bus_read(A_CTRL, rd); check("ctrl_readback", rd, {24'h0, CTRL_EXP});
      bus_read(A_STS, rd);  check("status_flushed", rd, 8'h0A);

      // Reset during a read cycle
      bus_write(A_DATA, 8'h77, 1'b0);
      dev_push(8'h44);
      CS = 1'b1; IOM = 1'b1; ADDR = A_DATA; RD_N = 1'b0;
      @(negedge CLK);
      check("midrd_oe", DATA_OE, 1'b1);
      check("midrd_data", DATA_OUT, 8'h44);
      #2 RESET_N = 1'b0;
      #1;
      check("midrd_rst_oe", DATA_OE, 1'b0);
      check("midrd_rst_dout", DATA_OUT, 8'h00);
      check("midrd_rst_tx_valid", TX_VALID, 1'b0);
      check("midrd_rst_rx_ready", RX_READY, 1'b1);
      @(negedge CLK);
      RD_N = 1'b1; CS = 1'b0; RESET_N = 1'b1;
      @(negedge CLK);

      // Reset during a write cycle
      CS = 1'b1; IOM = 1'b1; ADDR = A_DATA; DATA_IN = 8'h99; WR_N = 1'b0;
      @(negedge CLK);
      #2 RESET_N = 1'b0;
      #1;
      check("midwr_rst_oe", DATA_OE, 1'b0);
      check("midwr_rst_tx_valid", TX_VALID, 1'b0);
      @(negedge CLK);
      WR_N = 1'b1; CS = 1'b0; RESET_N = 1'b1;
      @(negedge CLK);
      check("midwr_no_commit", TX_VALID, 1'b0);
      bus_read(A_CNT, rd); check("count_after_midwr", rd, 8'h00);
      bus_read(A_STS, rd); check("status_after_midwr", rd, 8'h0A);

      // Interrupt on RX non-empty
      bus_write(A_CTRL, 8'h01, 1'b0);
      dev_push(8'h55);
      check("intr_not_yet", INTR, 1'b0);
      @(negedge CLK);
      check("intr_rx", INTR, IRQ_ON);
      bus_read(A_DATA, rd); check("rx_pop_55", rd, 8'h55);
      check("intr_hold_after_pop", INTR, IRQ_ON);
      @(negedge CLK);
      check("intr_cleared", INTR, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/io_fifo_port.md
Name: io_fifo_port

Overview:
- I/O-mapped byte FIFO peripheral on the 8088 bus, downstream of the address latch (consumes latched Address) and transceiver (consumes/drives Data).
- Decoded by the same chip-select scheme as the memory/IO models.
- CPU writes to the DATA port push into a TX FIFO that drains to a device-side stream.
- The device-side stream fills an RX FIFO that the CPU reads from the same DATA port. Status and control registers sit beside it.

Parameters:
- BASE, 16'h1C10, I/O base address; registers at BASE+0..BASE+3, all other addresses ignored.
- DEPTH, 8, entries per FIFO; power of two, 2..16.
- AW, $clog2(DEPTH), pointer width; counts are AW+1 bits.

Ports:
- CLK  in  1  bus clock
- RESET_N  in  1  asynchronous, active-low reset
- CS  in  1  chip select from top-level decode (IOM=1 region)
- IOM  in  1  1 = I/O cycle
- ADDR  in  20  latched bus address; only [15:0] compared
- RD_N  in  1  bus read strobe, active low
- WR_N  in  1  bus write strobe, active low
- DATA_IN  in  8  write data from transceiver
- DATA_OUT  out  8  read data to transceiver
- DATA_OE  out  1  drive enable for DATA_OUT
- TX_DATA  out  8  device-side TX head
- TX_VALID  out  1  TX FIFO non-empty
- TX_READY  in  1  device accepts TX_DATA
- RX_DATA  in  8  device-side RX byte
- RX_VALID  in  1  RX_DATA valid
- RX_READY  out  1  RX FIFO not full
- INTR  out  1  interrupt request (optional feature only; tied 0 otherwise)

Behaviour:
- Register map (offset, R/W):
  - 0 DATA: R pops RX; W pushes TX.
  - 1 STATUS, R: [0]tx_full [1]tx_empty [2]rx_full [3]rx_empty [4]tx_ovf [5]rx_udf [7:6]=0. A read clears [5:4] at end of cycle.
  - 2 COUNT, R: {rx_count[3:0], tx_count[3:0]}.
  - 3 CTRL, R/W: [0]rx_irq_en [1]tx_irq_en [7]flush (write-1 self-clearing: empties both FIFOs, no sticky change).
- hit = CS & IOM & (ADDR[15:2] == BASE[15:2]).
- Bus FSM, states IDLE, RD_ACT, WR_ACT; RD_N/WR_N sampled on posedge CLK.
  - IDLE→RD_ACT: hit & !RD_N. IDLE→WR_ACT: hit & !WR_N. Both strobes low is treated as a write.
  - RD_ACT: DATA_OE=1; DATA_OUT registered one cycle after entry, held stable while RD_N low. On first sample with RD_N high: perform pop/clear side effect, DATA_OE=0, go to IDLE.
  - WR_ACT: capture DATA_IN every cycle WR_N is low. On first sample with WR_N high: commit last captured byte (push or register write), go to IDLE.
  - Exactly one side effect per bus cycle regardless of strobe width.
- Boundary rules:
  - Pop of empty RX: DATA_OUT=8'h00, rx_udf set, pointers unchanged.
  - Push to full TX: byte dropped, tx_ovf set.
  - Device side: TX pops when TX_VALID & TX_READY. RX pushes when RX_VALID & RX_READY. RX_VALID while full is ignored; the device must honour RX_READY.
  - CPU push and device pop of TX in the same cycle: both occur, count unchanged (also when full). The same holds for RX.
  - Flush coincident with a device push/pop: flush wins.
  - Pointers wrap modulo DEPTH; full/empty come from the AW+1-bit count.
- Reset (async, any time, including mid-bus-cycle):
  - state=IDLE, DATA_OE=0, DATA_OUT=0.
  - Both FIFOs empty (TX_VALID=0, RX_READY=1), sticky bits 0, CTRL=0, INTR=0.
  - Storage contents are don't-care.
- Latency: CPU push visible on TX_VALID the cycle after the commit. Device RX push visible in STATUS/DATA the next cycle.

Optional Feature:
- Macro IO_FIFO_IRQ_EN.
- Defined: INTR is registered, = (rx_irq_en & !rx_empty) | (tx_irq_en & tx_empty); updates one cycle after the FIFO state changes. CTRL[1:0] are writable.
- Undefined: INTR tied 0; CTRL[1:0] read 0 and writes to them are ignored; flush still works.

Decomposition:
- Package io_fifo_pkg: register offset constants, STATUS/CTRL bit-index constants, bus FSM state enum.
- One sub-module, sync_fifo (parameters DEPTH and W=8; push, pop, flush, count, full, empty, head), instantiated once for TX and once for RX.

Test Plan:
- Reset then read STATUS at BASE+1 → 8'h0A (tx_empty, rx_empty), COUNT=8'h00, TX_VALID=0, RX_READY=1.
- Write 8'hA5, 8'h3C to BASE+0 with TX_READY=0 → COUNT=8'h02. Then TX_READY=1 → TX_DATA 8'hA5 then 8'h3C over two cycles, TX_VALID drops.
- Nine writes with DEPTH=8, TX_READY=0 → STATUS=8'h19 (tx_ovf, tx_full, rx_empty); a second STATUS read → 8'h09.
- Device pushes 8'h11, 8'h22; CPU reads BASE+0 twice → 8'h11, 8'h22. A third read → 8'h00 and STATUS bit5 set.
- TX full with TX_READY=1 while the CPU writes in the same cycle → count stays 8, no overflow, byte order preserved. Also assert RESET_N low mid-write: DATA_OE=0 and the FIFOs come up empty.
- With IO_FIFO_IRQ_EN defined: write CTRL=8'h01, device pushes 8'h55 → INTR=1 the following cycle; CPU reads DATA → INTR=0 the cycle after the pop.
